// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes two raw coin sensors, debounces a single-sensor
// insertion and issues a one-cycle coin code; flags invalid double insertions.
// Latency: coin high DEBOUNCE_CYCLES+2 edges after the first edge that samples
// the sensor high. Backpressure: inhibit blocks new coins and aborts debouncing.
//
// Ports:
//   clk      - single clock, rising edge
//   rstn     - synchronous active-low reset
//   sense_1  - raw 1-unit sensor level (asynchronous)
//   sense_2  - raw 2-unit sensor level (asynchronous)
//   inhibit  - downstream busy, no new coins accepted while high
//   coin     - registered coin code: 00 none, 01 one unit, 10 two units
//   reject   - registered one-cycle pulse on a double-sensor insertion
//   tally    - saturating credited value (only with COIN_TALLY_EN)
//
// Optional feature macro: COIN_TALLY_EN (adds the tally port/accumulator).

module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sense_1,
    input  logic       sense_2,
    input  logic       inhibit,
`ifdef COIN_TALLY_EN
    output logic [7:0] tally,
`endif
    output logic [1:0] coin,
    output logic       reject
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        ISSUE        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] cand_q, cand_d;
    logic [1:0] coin_d;
    logic       reject_d;

    // Two-flop synchronizer, bit 0 = sense_1, bit 1 = sense_2.
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] s;

    // Marks when the synchronizer output reflects sensor levels sampled after
    // reset. Without it a sensor held through reset would look released (the
    // flops reset to 0) and the FSM would credit it on the way back to IDLE.
    logic [1:0] sync_vld_q;

    assign s = sync2_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            sync_vld_q <= 2'b00;
        end else begin
            sync1_q    <= {sense_2, sense_1};
            sync2_q    <= sync1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= 8'd0;
            cand_q  <= 2'b00;
            coin    <= 2'b00;
            reject  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            coin    <= coin_d;
            reject  <= reject_d;
        end
    end

    // Outputs are computed from the transition being taken and registered, so
    // coin is high exactly while the FSM sits in ISSUE and reject is high for
    // the cycle after the offending transition.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        coin_d   = 2'b00;
        reject_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!inhibit) begin
                    if (s == 2'b11) begin
                        state_d  = WAIT_RELEASE;
                        reject_d = 1'b1;
                    end else if (s != 2'b00) begin
                        state_d = DEBOUNCE;
                        cand_d  = s;
                        cnt_d   = 8'd0;
                    end
                end
            end

            DEBOUNCE: begin
                if (s == 2'b00) begin
                    state_d = IDLE;                 // glitch, discard
                end else if (s == 2'b11) begin
                    state_d  = WAIT_RELEASE;
                    reject_d = 1'b1;
                end else if (inhibit) begin
                    state_d = WAIT_RELEASE;         // coin returned, no credit
                end else if (s == cand_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ISSUE;
                        coin_d  = cand_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    // Sensor swapped mid-debounce: not a clean insertion, so
                    // wait for the slot to clear rather than risk a credit.
                    state_d = WAIT_RELEASE;
                end
            end

            ISSUE: begin
                state_d = WAIT_RELEASE;
            end

            WAIT_RELEASE: begin
                if (sync_vld_q[1] && (s == 2'b00)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = WAIT_RELEASE;
            end
        endcase
    end

`ifdef COIN_TALLY_EN
    logic [7:0] tally_d;
    logic [8:0] tally_sum;

    always_comb begin
        tally_sum = {1'b0, tally} + {7'b0, cand_q};
        tally_d   = tally;
        if (state_q == ISSUE) begin
            tally_d = tally_sum[8] ? 8'hFF : tally_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tally <= 8'd0;
        end else begin
            tally <= tally_d;
        end
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor with DEBOUNCE_CYCLES=4.
// Edge k of a scenario is the k-th rising edge after stimulus is applied;
// outputs are sampled 1 time unit after each edge.

module tb_coin_acceptor;

    logic       clk;
    logic       rstn;
    logic       sense_1;
    logic       sense_2;
    logic       inhibit;
    logic [1:0] coin;
    logic       reject;
`ifdef COIN_TALLY_EN
    logic [7:0] tally;
`endif

    int total;
    int bad;
    int exp_tally;

    coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sense_1 (sense_1),
        .sense_2 (sense_2),
        .inhibit (inhibit),
`ifdef COIN_TALLY_EN
        .tally   (tally),
`endif
        .coin    (coin),
        .reject  (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drives one scenario for 'watch' edges and checks coin/reject at each.
    // Sensor(s) 'sens' sampled high at edges 0..hold-1, inhibit high at edges
    // inh_on..inh_off-1, rstn low at edge rst_at (-1 for none). The expected
    // coin 'code' appears only after edge coin_at, reject only after rej_at.
    task automatic run_pulse(input string tag, input logic [1:0] sens, input int hold,
                             input int inh_on, input int inh_off, input int rst_at,
                             input int watch, input int coin_at, input logic [1:0] code,
                             input int rej_at);
        for (int k = 0; k < watch; k++) begin
            sense_1 = (k < hold) ? sens[0] : 1'b0;
            sense_2 = (k < hold) ? sens[1] : 1'b0;
            inhibit = (k >= inh_on) && (k < inh_off);
            rstn    = (k != rst_at);
            @(posedge clk);
            #1;
            check({tag, " coin"}, 32'(coin), (k == coin_at) ? 32'(code) : 32'd0);
            check({tag, " reject"}, 32'(reject), (k == rej_at) ? 32'd1 : 32'd0);
        end
        if (rst_at >= 0) exp_tally = 0;
        if (coin_at >= 0) begin
            exp_tally = exp_tally + ((code == 2'b01) ? 1 : 2);
            if (exp_tally > 255) exp_tally = 255;
        end
`ifdef COIN_TALLY_EN
        check({tag, " tally"}, 32'(tally), 32'(exp_tally));
`endif
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_tally = 0;
        rstn      = 1'b0;
        sense_1   = 1'b0;
        sense_2   = 1'b0;
        inhibit   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset coin", 32'(coin), 32'd0);
        check("reset reject", 32'(reject), 32'd0);
`ifdef COIN_TALLY_EN
        check("reset tally", 32'(tally), 32'd0);
`endif
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Inhibit held in IDLE: sensor ignored, no coin.
        run_pulse("idle_inhibit", 2'b01, 8, 0, 12, -1, 16, -1, 2'b00, -1);
        // Short 3-cycle glitch on sense_2: discarded.
        run_pulse("glitch", 2'b10, 3, 0, 0, -1, 10, -1, 2'b00, -1);
        // Clean 1-unit coin held 10 cycles: coin=01 only after edge 6.
        run_pulse("coin1", 2'b01, 10, 0, 0, -1, 16, 6, 2'b01, -1);
        // Both sensors 8 cycles: one reject after edge 2, no coin.
        run_pulse("both", 2'b11, 8, 0, 0, -1, 14, -1, 2'b00, 2);
        // Inhibit raised mid-debounce with sense_1 held: coin returned.
        run_pulse("deb_inhibit", 2'b01, 12, 4, 7, -1, 18, -1, 2'b00, -1);
        // Reinsertion after release with inhibit low: credited once.
        run_pulse("reinsert1", 2'b01, 8, 0, 0, -1, 14, 6, 2'b01, -1);
        // Reset mid-debounce with sense_2 still held: never credited.
        run_pulse("rst_deb", 2'b10, 12, 0, 0, 3, 18, -1, 2'b00, -1);
        // Reinsertion of the 2-unit coin: credited as 10.
        run_pulse("reinsert2", 2'b10, 8, 0, 0, -1, 14, 6, 2'b10, -1);

`ifdef COIN_TALLY_EN
        // 130 two-unit insertions drive the tally into saturation.
        for (int i = 0; i < 130; i++) begin
            run_pulse("sat", 2'b10, 6, 0, 0, -1, 12, 6, 2'b10, -1);
        end
        check("tally saturated", 32'(tally), 32'd255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
